// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard sequencer and the IF/ID/EX/MEM/WB stages.
// The sequencer sits on the slave side: it receives pipeline events and returns
// the front-end block/flush controls plus its current state.
interface pipeline_hazard_ctrl_if;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       id_issue;
  logic [4:0] id_rd;
  logic       id_mem_read;
  logic       ex_redirect;
  logic       mem_busy;
  logic       wb_load_done;
  logic [4:0] wb_rd;
  logic       block;
  logic       pipeline_flush;
  logic [1:0] state_o;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, id_issue, id_rd, id_mem_read,
           ex_redirect, mem_busy, wb_load_done, wb_rd,
    input  block, pipeline_flush, state_o
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, id_issue, id_rd, id_mem_read,
           ex_redirect, mem_busy, wb_load_done, wb_rd,
    output block, pipeline_flush, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencer: tracks outstanding load destinations, stalls decode on
// load-use hazards, freezes on a busy data memory and holds a timed flush
// after an EX-stage redirect. Also keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MEMW  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t      state;
  state_t      state_next;
  logic [2:0]  flush_left;
  logic [2:0]  flush_left_next;
  logic [31:0] sb;
  logic [31:0] sb_next;
  logic        load_issue;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        haz;

  assign hz.state_o = state;

  // Hazard detection, scoreboard update and next-state selection
  always_comb begin
    load_issue = hz.id_issue & hz.id_mem_read & (hz.id_rd != 5'd0);
    rs1_hit    = (hz.dec_rs1 != 5'd0) &
                 (sb[hz.dec_rs1] | (load_issue & (hz.id_rd == hz.dec_rs1)));
    rs2_hit    = (hz.dec_rs2 != 5'd0) &
                 (sb[hz.dec_rs2] | (load_issue & (hz.id_rd == hz.dec_rs2)));
    haz        = hz.dec_valid & (rs1_hit | rs2_hit);

    sb_next = sb;
    if (hz.ex_redirect) begin
      sb_next = '0;
    end else begin
      if (hz.wb_load_done) sb_next[hz.wb_rd] = 1'b0;
      if (load_issue)      sb_next[hz.id_rd] = 1'b1;
    end

    flush_left_next = flush_left;
    if (hz.ex_redirect) begin
      state_next      = FLUSH;
      flush_left_next = FLUSH_LOAD;
    end else if ((state == FLUSH) && (flush_left != 3'd0)) begin
      state_next      = FLUSH;
      flush_left_next = flush_left - 3'd1;
    end else if (hz.mem_busy) begin
      state_next = MEMW;
    end else if (haz) begin
      state_next = HAZ;
    end else begin
      state_next = RUN;
    end
  end

  // State register with Moore outputs registered alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      flush_left        <= 3'd0;
      hz.block          <= 1'b0;
      hz.pipeline_flush <= 1'b0;
    end else begin
      state             <= state_next;
      flush_left        <= flush_left_next;
      hz.block          <= (state_next == HAZ) || (state_next == MEMW);
      hz.pipeline_flush <= (state_next == FLUSH);
    end
  end

  // Outstanding-load scoreboard, one bit per architectural register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

  // Saturating stall and redirect performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.block && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (hz.ex_redirect && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the in-order pipeline front end.
- Generates the block and pipeline_flush controls consumed by the IF and ID stages.
- Tracks outstanding load destinations in a 32-entry scoreboard and stalls decode on load-use hazards.
- Freezes the front end while data memory is busy and drives a timed flush after an EX-stage redirect (taken branch, JAL/JALR, CSR/trap redirect). Exposes stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles pipeline_flush is held after a redirect (1..7).
- CNT_W, 32, width of each saturating performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  IF has a new instruction presented to ID (if_finish)
- dec_rs1  in  5  rs1 field of instruction presented to ID
- dec_rs2  in  5  rs2 field of instruction presented to ID
- id_issue  in  1  ID produced a valid decoded instruction this cycle (id_finish)
- id_rd  in  5  destination of issuing instruction
- id_mem_read  in  1  issuing instruction is a load/AMO
- ex_redirect  in  1  EX resolved a control transfer; younger instructions invalid
- mem_busy  in  1  data memory access outstanding, MEM cannot accept
- wb_load_done  in  1  a load result is written back this cycle
- wb_rd  in  5  destination of that load
- block  out  1  hold IF/ID registers (to ID_stage block and IF stall)
- pipeline_flush  out  1  squash IF/ID contents
- state_o  out  2  current FSM state (RUN=0, HAZ=1, MEMW=2, FLUSH=3)
- stall_cnt  out  CNT_W  cycles with block=1
- flush_cnt  out  CNT_W  number of redirects accepted

Behaviour:
- Reset (async): state=RUN, scoreboard=0, flush counter=0, stall_cnt=0, flush_cnt=0. Outputs during reset: block=0, pipeline_flush=0, state_o=0.
- Scoreboard set: on id_issue & id_mem_read & id_rd!=0, set bit id_rd at posedge.
- Scoreboard clear: on wb_load_done, clear bit wb_rd. Same-cycle set and clear of the same register: set wins. x0 is never set.
- Hazard (combinational): haz = dec_valid & ((sb[dec_rs1] & dec_rs1!=0) | (sb[dec_rs2] & dec_rs2!=0)). It also counts as a hazard when id_issue & id_mem_read & id_rd!=0 matches a nonzero rs1/rs2, so back-to-back load-use is caught before the bit registers.
- Next-state priority, evaluated every cycle from any state: ex_redirect > mem_busy > haz.
  - ex_redirect → FLUSH with counter=FLUSH_CYCLES-1; also clear the entire scoreboard, except bits set by an issuing load in the same cycle, which are dropped too.
  - else mem_busy → MEMW.
  - else haz → HAZ.
  - else → RUN.
  - Exception: FLUSH stays in FLUSH while counter!=0, decrementing each cycle. A new ex_redirect in FLUSH reloads the counter.
- Outputs (Moore, registered from state):
  - RUN: block=0, flush=0.
  - HAZ: block=1, flush=0.
  - MEMW: block=1, flush=0.
  - FLUSH: block=0, flush=1.
  - Consequence: stall/flush take effect the cycle after the triggering input; latency is exactly 1 cycle.
- HAZ exits to RUN in the cycle after the blocking scoreboard bit clears (wb_load_done observed).
- mem_busy held indefinitely keeps MEMW; no timeout.
- Counters:
  - stall_cnt increments on each cycle with block=1.
  - flush_cnt increments on each cycle ex_redirect is accepted.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush returns to RUN immediately, with scoreboard and counters cleared.

Test Plan:
- Reset while in FLUSH with stall_cnt=5 → next cycle state_o=0, block=0, pipeline_flush=0, stall_cnt=0, flush_cnt=0.
- Load-use, back to back:
  - Stimulus: issue id_mem_read, id_rd=5, then dec_valid with dec_rs1=5; wb_load_done with wb_rd=5 arrives 3 cycles later.
  - Response: block=1 for 3 cycles, then 0.
  - Same stimulus with rd=0 → never blocks.
- Redirect with FLUSH_CYCLES=2: ex_redirect pulse at cycle t → pipeline_flush=1 at t+1 and t+2, 0 at t+3; flush_cnt=1; scoreboard empty (rs1=5 no longer stalls).
- Priority: ex_redirect, mem_busy and hazard asserted in the same cycle → FLUSH entered. If mem_busy is still high when the flush ends → MEMW (block=1) next.
- mem_busy high for 4 cycles with no hazard → block=1 for exactly 4 cycles starting 1 cycle after assertion; stall_cnt increments by 4.
- Saturation with CNT_W=4: 20 stall cycles → stall_cnt=15 and holds.
